sbc_mem_responder: RTL and testbench
====================================

Name: sbc_mem_responder

Overview:
- Memory-side responder for the single-cycle SBC core.
- Holds instruction memory (IMEM) and data memory (DMEM) and answers the core's instruction fetch and load/store port combinationally in the same cycle. Stores commit on the clock edge.
- Contains a host loader FSM that fills IMEM word-by-word over a valid/ready stream from the logic-analyzer side, then releases the core.
- During loading the core is held in reset and fed NOPs via insMemEn.

Parameters:
- WIDTH, 32, data/instruction word width
- IMEM_DEPTH, 512, IMEM words; address width $clog2(IMEM_DEPTH)
- DMEM_DEPTH, 32, DMEM words; address width $clog2(DMEM_DEPTH)

Ports:
- clock  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- hostStart  input  1  one-cycle pulse; begin IMEM load.
- hostLen  input  $clog2(IMEM_DEPTH)  words to load; 0 means IMEM_DEPTH.
- hostValid  input  1  hostData valid.
- hostData  input  WIDTH  instruction word to load.
- hostReady  output  1  loader accepts a word this cycle.
- hostDone  output  1  one-cycle pulse when the last word is written.
- insMemAddr  input  $clog2(IMEM_DEPTH)  core fetch word address.
- insMemDataIn  output  WIDTH  fetched instruction, combinational.
- insMemEn  output  1  high forces the core to a NOP (hold).
- coreReset  output  1  active-low reset to the core.
- dataMemAddr  input  $clog2(DMEM_DEPTH)  core data word address.
- dataMemWen  input  1  core store enable.
- dataMemDataOut  input  WIDTH  core store data.
- dataMemDataIn  output  WIDTH  load data, combinational.

Behaviour:
- FSM states: IDLE, LOAD, RELEASE, RUN.
- Reset (asynchronous, active-low):
  - State goes to IDLE; load counter = 0.
  - hostReady = 0, hostDone = 0, insMemEn = 1, coreReset = 0.
  - Memory contents are not cleared.
- IDLE:
  - insMemEn = 1, coreReset = 0, hostReady = 0.
  - hostStart → LOAD; latch hostLen into the target count (0 → IMEM_DEPTH); counter = 0.
- LOAD:
  - hostReady = 1.
  - On hostValid & hostReady: IMEM[counter] <= hostData; counter++.
  - When the accepted word is number target (counter == target-1): pulse hostDone for the next cycle, go to RELEASE.
  - hostValid low → no write, no advance; stalls are unlimited.
  - hostStart during LOAD is ignored.
- RELEASE:
  - Lasts one cycle. coreReset = 0, insMemEn = 1, hostReady = 0. Then go to RUN.
  - Guarantees the core sees at least one reset edge after the last write.
- RUN:
  - coreReset = 1, insMemEn = 0, hostReady = 0.
  - hostStart → LOAD; coreReset drops and insMemEn rises in the same cycle as the transition (registered outputs, asserted next edge). The counter restarts at 0.
- Outputs: coreReset, insMemEn and hostReady are registered, decoded from state.
- Fetch port: insMemDataIn = IMEM[insMemAddr], combinational in every state.
- Data port:
  - dataMemDataIn = DMEM[dataMemAddr], combinational.
  - On clock edge: if dataMemWen & (state == RUN), DMEM[dataMemAddr] <= dataMemDataOut. Full-word write; no byte enables (sub-word stores arrive already truncated by the core).
  - dataMemWen outside RUN is ignored.
  - Read-during-write to the same address returns the old word in that cycle and the new word from the next cycle.
- Counter wrap: at most IMEM_DEPTH words per load; the counter never exceeds target-1. hostLen = 0 loads addresses 0..IMEM_DEPTH-1.
- Reset mid-LOAD: words already written stay in IMEM; state returns to IDLE; no hostDone.
- Simultaneous hostStart and final accepted word: cannot occur (hostStart is ignored in LOAD).

Test Plan:
- Reset, then hostStart with hostLen=4; stream words 0x00100093, 0x00200113, 0x002081B3, 0x0000006F with hostValid held high → hostReady high 4 cycles; IMEM[0..3] hold those words; hostDone pulses once; coreReset=0 for the RELEASE cycle then 1; insMemEn falls with it.
- Same load with hostValid toggling 1,0,0,1,1,0,1 → exactly 4 writes at addresses 0..3 in order; no advance on valid=0 cycles; hostDone only after the 4th accepted word.
- In RUN: dataMemAddr=5, dataMemWen=1, dataMemDataOut=0xDEADBEEF → dataMemDataIn at addr 5 shows the old value that cycle and 0xDEADBEEF the next. In IDLE, the same stimulus leaves DMEM[5] unchanged.
- hostLen=0 load of 512 words with data = address → IMEM[511]=511, IMEM[0]=0 (no wrap overwrite); hostDone on the 512th word.
- Assert reset after 2 of 4 words → IDLE immediately (asynchronous); IMEM[0..1] retained; hostReady=0; coreReset=0; no hostDone.
- In RUN, pulse hostStart with hostLen=1 → next cycle coreReset=0 and insMemEn=1; one word loads to IMEM[0]; then RELEASE and RUN again.

Source files
------------

// File: rtl/sbc_mem_responder.sv
// Memory-side responder for the single-cycle SBC core: combinational IMEM/DMEM ports
// plus a host loader that streams a program into IMEM while holding the core in reset.
module sbc_mem_responder #(
  parameter  int WIDTH      = 32,
  parameter  int IMEM_DEPTH = 512,
  parameter  int DMEM_DEPTH = 32,
  localparam int IAW        = $clog2(IMEM_DEPTH),
  localparam int DAW        = $clog2(DMEM_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hostStart,
  input  logic [IAW-1:0]   hostLen,
  input  logic             hostValid,
  input  logic [WIDTH-1:0] hostData,
  output logic             hostReady,
  output logic             hostDone,
  input  logic [IAW-1:0]   insMemAddr,
  output logic [WIDTH-1:0] insMemDataIn,
  output logic             insMemEn,
  output logic             coreReset,
  input  logic [DAW-1:0]   dataMemAddr,
  input  logic             dataMemWen,
  input  logic [WIDTH-1:0] dataMemDataOut,
  output logic [WIDTH-1:0] dataMemDataIn
);

  // state     | meaning
  // S_IDLE    | core held in reset, waiting for hostStart
  // S_LOAD    | accepting host words into IMEM
  // S_RELEASE | one extra reset cycle after the last write
  // S_RUN     | core running; DMEM stores enabled
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] imem [IMEM_DEPTH];
  logic [WIDTH-1:0] dmem [DMEM_DEPTH];

  logic [IAW-1:0] load_cnt;
  logic [IAW-1:0] target_m1;   // hostLen-1; hostLen=0 wraps to IMEM_DEPTH-1
  logic           load_fire;
  logic           last_word;
  logic           start_load;

  always_comb begin
    next_state = state;
    load_fire  = 1'b0;
    last_word  = 1'b0;
    start_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (hostStart) begin
          start_load = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (hostValid) begin
          load_fire = 1'b1;
          if (load_cnt == target_m1) begin
            last_word  = 1'b1;
            next_state = S_RELEASE;
          end
        end
      end
      S_RELEASE: next_state = S_RUN;
      S_RUN: begin
        if (hostStart) begin
          start_load = 1'b1;
          next_state = S_LOAD;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they track the state register exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      target_m1 <= '0;
      hostDone  <= 1'b0;
      hostReady <= 1'b0;
      insMemEn  <= 1'b1;
      coreReset <= 1'b0;
    end else begin
      state     <= next_state;
      hostDone  <= last_word;
      hostReady <= (next_state == S_LOAD);
      insMemEn  <= (next_state != S_RUN);
      coreReset <= (next_state == S_RUN);
      if (start_load) begin
        target_m1 <= hostLen - IAW'(1);
        load_cnt  <= '0;
      end else if (load_fire) begin
        load_cnt  <= last_word ? '0 : load_cnt + IAW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (load_fire) imem[load_cnt] <= hostData;
  end

  always_ff @(posedge clock) begin
    if (dataMemWen && (state == S_RUN)) dmem[dataMemAddr] <= dataMemDataOut;
  end

  assign insMemDataIn  = imem[insMemAddr];
  assign dataMemDataIn = dmem[dataMemAddr];

endmodule

// File: tb/tb_sbc_mem_responder.sv
// Bench for sbc_mem_responder: directed load/run scenarios plus a random soak,
// all checked every cycle against a transaction-level model of the loader and memories.
module tb_sbc_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hostStart = 1'b0;
  logic [8:0]  hostLen = '0;
  logic        hostValid = 1'b0;
  logic [31:0] hostData = '0;
  logic        hostReady, hostDone;
  logic [8:0]  insMemAddr = '0;
  logic [31:0] insMemDataIn;
  logic        insMemEn, coreReset;
  logic [4:0]  dataMemAddr = '0;
  logic        dataMemWen = 1'b0;
  logic [31:0] dataMemDataOut = '0;
  logic [31:0] dataMemDataIn;

  sbc_mem_responder dut (
    .clock(clock), .reset(reset),
    .hostStart(hostStart), .hostLen(hostLen), .hostValid(hostValid), .hostData(hostData),
    .hostReady(hostReady), .hostDone(hostDone),
    .insMemAddr(insMemAddr), .insMemDataIn(insMemDataIn), .insMemEn(insMemEn),
    .coreReset(coreReset),
    .dataMemAddr(dataMemAddr), .dataMemWen(dataMemWen), .dataMemDataOut(dataMemDataOut),
    .dataMemDataIn(dataMemDataIn)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 loading, 2 release, 3 running
  logic [31:0] m_imem [512];
  bit          m_ik   [512];
  logic [31:0] m_dmem [32];
  bit          m_dk   [32];
  int          m_mode = 0;
  int          m_left = 0;
  int          m_addr = 0;
  bit          m_done = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode == 0) begin
        if (hostStart) begin
          m_mode = 1; m_left = (hostLen == 0) ? 512 : int'(hostLen); m_addr = 0;
        end
      end else if (m_mode == 1) begin
        if (hostValid) begin
          m_imem[m_addr] = hostData;
          m_ik[m_addr]   = 1;
          m_addr++;
          m_left--;
          if (m_left == 0) begin
            m_done = 1;
            m_mode = 2;
          end
        end
      end else if (m_mode == 2) begin
        m_mode = 3;
      end else begin
        if (dataMemWen) begin
          m_dmem[dataMemAddr] = dataMemDataOut;
          m_dk[dataMemAddr]   = 1;
        end
        if (hostStart) begin
          m_mode = 1; m_left = (hostLen == 0) ? 512 : int'(hostLen); m_addr = 0;
        end
      end
    end
  end

  bit chk_en = 0;
  int ready_seen = 0;
  int done_seen  = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("hostReady", {31'b0, hostReady}, {31'b0, m_mode == 1});
      chk("hostDone",  {31'b0, hostDone},  {31'b0, m_done});
      chk("coreReset", {31'b0, coreReset}, {31'b0, m_mode == 3});
      chk("insMemEn",  {31'b0, insMemEn},  {31'b0, m_mode != 3});
      if (m_ik[insMemAddr])  chk("fetch", insMemDataIn,  m_imem[insMemAddr]);
      if (m_dk[dataMemAddr]) chk("load",  dataMemDataIn, m_dmem[dataMemAddr]);
      ready_seen += int'(hostReady);
      done_seen  += int'(hostDone);
    end
  end

  logic [31:0] ld_data [512];

  // vmode: 0 valid always high, 1 fixed toggle pattern, 2 random
  task automatic do_load(input int n, input int vmode);
    int sent = 0;
    int cyc  = 0;
    bit r;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    hostLen   = 9'(n);
    hostStart = 1;
    hostValid = 0;
    @(posedge clock); #1;
    hostStart = 0;
    chk("start_ready",     {31'b0, hostReady}, 32'd1);
    chk("start_coreReset", {31'b0, coreReset}, 32'd0);
    chk("start_insMemEn",  {31'b0, insMemEn},  32'd1);
    while (sent < n && cyc < 4000) begin
      if (vmode == 0)      hostValid = 1;
      else if (vmode == 1) hostValid = (pat[cyc % 7] != 0);
      else                 hostValid = 1'($urandom_range(0, 1));
      hostData = ld_data[sent];
      r = hostReady;
      @(posedge clock); #1;
      if (hostValid && r) sent++;
      cyc++;
    end
    hostValid = 0;
    chk("load_words_accepted", 32'(sent), 32'(n));
    chk("rel_hostDone",  {31'b0, hostDone},  32'd1);
    chk("rel_coreReset", {31'b0, coreReset}, 32'd0);
    chk("rel_insMemEn",  {31'b0, insMemEn},  32'd1);
    chk("rel_hostReady", {31'b0, hostReady}, 32'd0);
    @(posedge clock); #1;
    chk("run_coreReset", {31'b0, coreReset}, 32'd1);
    chk("run_insMemEn",  {31'b0, insMemEn},  32'd0);
    chk("run_hostDone",  {31'b0, hostDone},  32'd0);
  endtask

  task automatic fetch_is(input int a, input logic [31:0] exp, input string name);
    insMemAddr = 9'(a);
    #1;
    chk(name, insMemDataIn, exp);
  endtask

  int rs, ds;

  initial begin
    #2 reset = 0;
    #1 chk_en = 1;
    chk("rst_hostReady", {31'b0, hostReady}, 32'd0);
    chk("rst_hostDone",  {31'b0, hostDone},  32'd0);
    chk("rst_insMemEn",  {31'b0, insMemEn},  32'd1);
    chk("rst_coreReset", {31'b0, coreReset}, 32'd0);
    #9 reset = 1;
    @(posedge clock); #1;

    // Basic 4-word load with valid held high
    ld_data[0] = 32'h00100093; ld_data[1] = 32'h00200113;
    ld_data[2] = 32'h002081B3; ld_data[3] = 32'h0000006F;
    rs = ready_seen; ds = done_seen;
    do_load(4, 0);
    chk("basic_ready_cycles", 32'(ready_seen - rs), 32'd4);
    chk("basic_done_pulses",  32'(done_seen - ds),  32'd1);
    fetch_is(0, 32'h00100093, "basic_imem0");
    fetch_is(1, 32'h00200113, "basic_imem1");
    fetch_is(2, 32'h002081B3, "basic_imem2");
    fetch_is(3, 32'h0000006F, "basic_imem3");
    @(posedge clock); #1;

    // Same load from RUN with valid toggling 1,0,0,1,1,0,1
    for (int i = 0; i < 4; i++) ld_data[i] = 32'h11111111 * (i + 1);
    rs = ready_seen; ds = done_seen;
    do_load(4, 1);
    chk("toggle_ready_cycles", 32'(ready_seen - rs), 32'd7);
    chk("toggle_done_pulses",  32'(done_seen - ds),  32'd1);
    fetch_is(0, 32'h11111111, "toggle_imem0");
    fetch_is(3, 32'h44444444, "toggle_imem3");

    // DMEM read-during-write in RUN
    dataMemAddr = 5; dataMemWen = 1; dataMemDataOut = 32'h11111111;
    @(posedge clock); #1;
    dataMemDataOut = 32'hDEADBEEF;
    chk("rdw_old_word", dataMemDataIn, 32'h11111111);
    @(posedge clock); #1;
    dataMemWen = 0;
    chk("rdw_new_word", dataMemDataIn, 32'hDEADBEEF);

    // Stores ignored in IDLE; reset does not clear DMEM
    reset = 0; #2 reset = 1;
    @(posedge clock); #1;
    dataMemWen = 1; dataMemDataOut = 32'hCAFEF00D;
    @(posedge clock); #1;
    @(posedge clock); #1;
    dataMemWen = 0;
    chk("idle_store_ignored", dataMemDataIn, 32'hDEADBEEF);

    // Full-depth load via hostLen=0, data = address
    for (int i = 0; i < 512; i++) ld_data[i] = 32'(i);
    rs = ready_seen; ds = done_seen;
    do_load(512, 0);
    chk("full_ready_cycles", 32'(ready_seen - rs), 32'd512);
    chk("full_done_pulses",  32'(done_seen - ds),  32'd1);
    fetch_is(511, 32'd511, "full_imem511");
    fetch_is(0,   32'd0,   "full_imem0");
    fetch_is(300, 32'd300, "full_imem300");

    // Async reset after 2 of 4 words
    ds = done_seen;
    hostLen = 9'd4; hostStart = 1;
    @(posedge clock); #1;
    hostStart = 0; hostValid = 1; hostData = 32'hAAAA0000;
    @(posedge clock); #1;
    hostData = 32'hAAAA0001;
    @(posedge clock); #1;
    hostData = 32'hAAAA0002;
    reset = 0;
    #1;
    chk("midrst_hostReady", {31'b0, hostReady}, 32'd0);
    chk("midrst_coreReset", {31'b0, coreReset}, 32'd0);
    chk("midrst_insMemEn",  {31'b0, insMemEn},  32'd1);
    #2 reset = 1;
    hostValid = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("midrst_no_done", 32'(done_seen - ds), 32'd0);
    chk("midrst_still_idle", {31'b0, hostReady}, 32'd0);
    fetch_is(0, 32'hAAAA0000, "midrst_imem0");
    fetch_is(1, 32'hAAAA0001, "midrst_imem1");
    fetch_is(2, 32'd2,        "midrst_imem2_untouched");

    // Random-valid load to get into RUN, then a 1-word reload from RUN
    for (int i = 0; i < 6; i++) ld_data[i] = $urandom;
    do_load(6, 2);
    ld_data[0] = 32'h12345678;
    do_load(1, 0);
    fetch_is(0, 32'h12345678, "reload_imem0");
    fetch_is(1, ld_data[1],   "reload_imem1_kept");

    // Random soak across all inputs
    for (int c = 0; c < 800; c++) begin
      hostStart      = ($urandom_range(0, 15) == 0);
      hostLen        = 9'($urandom_range(1, 12));
      hostValid      = 1'($urandom_range(0, 1));
      hostData       = $urandom;
      insMemAddr     = 9'($urandom_range(0, 15));
      dataMemAddr    = 5'($urandom_range(0, 31));
      dataMemWen     = 1'($urandom_range(0, 1));
      dataMemDataOut = $urandom;
      @(posedge clock); #1;
    end
    hostStart = 0; hostValid = 0; dataMemWen = 0;
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
